cache_arbiter: RTL and testbench
================================

# cache_arbiter

Two-port arbiter that shares one line-granular physical-memory port between the instruction cache and the data cache. It sits between the `pmem_*` sides of the two `cache` instances and the single downstream memory or line adaptor. It grants one whole line transaction (read fill or write-back) at a time, using round-robin on conflict. While a transaction is in flight it passes address, data and handshake through unchanged.

## Interface
- `s_word`, 256, line width in bits; must match both caches and downstream memory.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_pmem_address`  in  32  I-cache line address.
- `i_pmem_read`  in  1  I-cache line read request; level, held until `i_pmem_resp`.
- `i_pmem_write`  in  1  I-cache line write request; level, held until `i_pmem_resp`.
- `i_pmem_wdata`  in  s_word  I-cache write-back data.
- `i_pmem_rdata`  out  s_word  read data to I-cache.
- `i_pmem_resp`  out  1  completion to I-cache.
- `d_pmem_address`, `d_pmem_read`, `d_pmem_write`, `d_pmem_wdata`, `d_pmem_rdata`, `d_pmem_resp`: same widths and meanings as the `i_` ports, for the D-cache.
- `pmem_address`  out  32  downstream address.
- `pmem_read`  out  1  downstream read strobe.
- `pmem_write`  out  1  downstream write strobe.
- `pmem_wdata`  out  s_word  downstream write data.
- `pmem_rdata`  in  s_word  downstream read data.
- `pmem_resp`  in  1  downstream completion; one-cycle pulse per transaction.

## Operation
- States: `IDLE`, `SERVE_I`, `SERVE_D`. A 1-bit register `last` records the most recently granted requester (I=0, D=1).
- A requester is pending when its read or write request is high.
- `IDLE`:
  - Only I pending: next state `SERVE_I`.
  - Only D pending: next state `SERVE_D`.
  - Both pending: grant the requester not equal to `last`.
  - Neither pending: stay in `IDLE`.
- `SERVE_x`: downstream outputs are driven combinationally from requester x. On `pmem_resp` = 1, go to `IDLE` and set `last` = x. Otherwise hold the state.
- `IDLE` outputs: `pmem_read` = `pmem_write` = 0, `pmem_address` = 0, `pmem_wdata` = 0.
- Read data: `pmem_rdata` is broadcast to both `i_pmem_rdata` and `d_pmem_rdata` at all times.
- Response routing: `x_pmem_resp` = `pmem_resp` only while in `SERVE_x`. It is 0 in every other state.
- A `pmem_resp` received in `IDLE` is ignored and not forwarded.
- A non-granted requester sees `resp` = 0 and simply waits. No request is dropped.
- A requester asserting read and write together is illegal. The bench flags it with an assertion. The arbiter forwards both strobes unchanged.
- Grant is fixed for the whole transaction. Requester inputs changing mid-transaction pass straight through; the caches guarantee they are stable.

## Timing
- Reset: state = `IDLE`, `last` = 0, so the first conflict after reset grants D. All outputs are 0 in the cycle after `rst` is sampled high.
- `rst` mid-transaction: the arbiter abandons the transaction and returns to `IDLE`. The downstream memory is reset by the same `rst`.
- Arbitration latency: request high in `IDLE` at cycle t → `SERVE_x` at t+1, with the downstream strobe visible combinationally in t+1.
- Completion: `pmem_resp` at cycle r → `x_pmem_resp` in the same cycle r (combinational) → `IDLE` at r+1.
- A waiting requester is granted at r+2, so there is one idle bubble between back-to-back transactions.
- A requester that deasserts its request at r+1 (normal cache behaviour) is not re-granted.
- Worst-case wait for one requester: one full transaction of the other requester plus 2 cycles.

## Structure
- Add to package `cache_types`:
  - `arb_state_t` enum {`IDLE`, `SERVE_I`, `SERVE_D`}.
  - `arb_sel_t` enum {`ARB_I`, `ARB_D`}, used for `last`.
- Single module. The next-state logic, `last` register and output muxes are small, so no sub-module.

## Test plan
- Only I reads 0x0000_0100; memory responds after 5 cycles with pattern A → `pmem_read` high from t+1; `i_pmem_resp` pulses once with `i_pmem_rdata` = A; `d_pmem_resp` stays 0.
- After reset, I read (0x100) and D write (0x200, data B) both rise in the same cycle → D served first (`pmem_write`=1, `pmem_address`=0x200, `pmem_wdata`=B). Then I is served at `pmem_resp`+2 with `pmem_address`=0x100.
- Both requesters hold requests continuously for 6 transactions → grants alternate D, I, D, I, D, I, and each requester receives exactly 3 `resp` pulses.
- `pmem_resp` pulsed while in `IDLE` with no requests → no `x_pmem_resp` asserted; state remains `IDLE`.
- `rst` asserted 2 cycles into a D write → next cycle `pmem_write`=0 and state `IDLE`. An I request held high afterwards is granted 1 cycle after `rst` deasserts.
- D write-back (0x300) followed immediately by D read (0x340), with I idle → two transactions separated by exactly one `IDLE` cycle; addresses are forwarded correctly.

Source files
------------

// File: rtl/cache_types.sv
// cache_types: shared line width and arbiter state/selection enums.
package cache_types;
  localparam int S_WORD = 256;
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} arb_state_t;
  typedef enum logic {ARB_I, ARB_D} arb_sel_t;
endpackage

// File: rtl/cache_arbiter.sv
// cache_arbiter: round-robin sharing of one line-granular memory port between I-cache and D-cache.
module cache_arbiter
  import cache_types::*;
#(
  parameter int s_word = S_WORD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       i_pmem_address,
  input  logic              i_pmem_read,
  input  logic              i_pmem_write,
  input  logic [s_word-1:0] i_pmem_wdata,
  output logic [s_word-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic [31:0]       d_pmem_address,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [s_word-1:0] d_pmem_wdata,
  output logic [s_word-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic [31:0]       pmem_address,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [s_word-1:0] pmem_wdata,
  input  logic [s_word-1:0] pmem_rdata,
  input  logic              pmem_resp
);
  arb_state_t state, state_n;
  arb_sel_t last, last_n;
  logic i_pend, d_pend, sel_i, sel_d;
  assign i_pend = i_pmem_read | i_pmem_write;
  assign d_pend = d_pmem_read | d_pmem_write;
  assign sel_i = state == SERVE_I;
  assign sel_d = state == SERVE_D;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      last <= ARB_I;
    end else begin
      state <= state_n;
      last <= last_n;
    end
  // on a conflict the requester that did not go last wins
  always_comb begin
    state_n = state;
    last_n = last;
    case (state)
      IDLE:
        state_n = (i_pend && d_pend) ? (last == ARB_I ? SERVE_D : SERVE_I)
                : i_pend ? SERVE_I : d_pend ? SERVE_D : IDLE;
      SERVE_I:
        if (pmem_resp) begin
          state_n = IDLE;
          last_n = ARB_I;
        end
      SERVE_D:
        if (pmem_resp) begin
          state_n = IDLE;
          last_n = ARB_D;
        end
      default: state_n = IDLE;
    endcase
  end
  assign pmem_address = sel_i ? i_pmem_address : sel_d ? d_pmem_address : '0;
  assign pmem_read = sel_i ? i_pmem_read : sel_d ? d_pmem_read : 1'b0;
  assign pmem_write = sel_i ? i_pmem_write : sel_d ? d_pmem_write : 1'b0;
  assign pmem_wdata = sel_i ? i_pmem_wdata : sel_d ? d_pmem_wdata : '0;
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;
  assign i_pmem_resp = sel_i & pmem_resp;
  assign d_pmem_resp = sel_d & pmem_resp;
endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: table-driven and scenario checks with a transaction scoreboard and a simple memory model.
module tb_cache_arbiter;
  localparam int W = 256;
  logic clk = 0, rst = 1;
  logic [31:0] i_pmem_address = 0, d_pmem_address = 0, pmem_address;
  logic i_pmem_read = 0, i_pmem_write = 0, d_pmem_read = 0, d_pmem_write = 0;
  logic [W-1:0] i_pmem_wdata = 0, d_pmem_wdata = 0, i_pmem_rdata, d_pmem_rdata, pmem_wdata, pmem_rdata;
  logic i_pmem_resp, d_pmem_resp, pmem_read, pmem_write, pmem_resp, mem_resp, force_resp = 0;
  int lat = 5, mem_cnt;
  always #5 clk = ~clk;

  cache_arbiter dut (
    .clk(clk), .rst(rst),
    .i_pmem_address(i_pmem_address), .i_pmem_read(i_pmem_read), .i_pmem_write(i_pmem_write),
    .i_pmem_wdata(i_pmem_wdata), .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_address(d_pmem_address), .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_wdata(d_pmem_wdata), .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  function automatic logic [W-1:0] pattern(input logic [31:0] a);
    return {8{a ^ 32'hA5A5_5A5A}};
  endfunction

  // downstream memory: one resp pulse lat cycles after a strobe appears
  assign pmem_resp = mem_resp | force_resp;
  always @(posedge clk)
    if (rst) begin
      mem_resp <= 0;
      mem_cnt <= 0;
      pmem_rdata <= '0;
    end else begin
      mem_resp <= 0;
      if ((pmem_read | pmem_write) && !mem_resp) begin
        if (mem_cnt == lat - 1) begin
          mem_resp <= 1;
          mem_cnt <= 0;
          pmem_rdata <= pattern(pmem_address);
        end else mem_cnt <= mem_cnt + 1;
      end else mem_cnt <= 0;
    end

  always @(negedge clk)
    assert (!(i_pmem_read && i_pmem_write) && !(d_pmem_read && d_pmem_write))
      else $error("illegal simultaneous read and write request");

  typedef struct {
    logic is_d;
    logic wr;
    logic [31:0] addr;
    logic [W-1:0] wdata;
  } txn_t;
  txn_t sb[$];

  typedef struct {
    logic ir, iw, dr, dw;
    logic [31:0] ia, da;
    logic [W-1:0] iwd, dwd;
    logic d_first;
    int lat;
  } vec_t;
  vec_t vecs[6];

  int checks = 0, fails = 0, since_resp = 100, i_cnt = 0, d_cnt = 0;
  logic hold = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_grant(input string name);
    txn_t e = sb[0];
    chk({name, "_rd"}, W'(pmem_read), W'(!e.wr));
    chk({name, "_wr"}, W'(pmem_write), W'(e.wr));
    chk({name, "_addr"}, W'(pmem_address), W'(e.addr));
  endtask

  task automatic tick();
    txn_t e;
    @(negedge clk);
    if (since_resp < 100) since_resp++;
    if (since_resp == 1) chk("bubble", W'({pmem_read, pmem_write}), W'(0));
    if (since_resp == 2 && sb.size() > 0) check_grant("grant");
    if (i_pmem_resp || d_pmem_resp) begin
      chk("resp_one", W'(i_pmem_resp & d_pmem_resp), W'(0));
      if (sb.size() == 0) chk("resp_unexpected", W'(1), W'(0));
      else begin
        e = sb.pop_front();
        chk("resp_who", W'(d_pmem_resp), W'(e.is_d));
        chk("resp_addr", W'(pmem_address), W'(e.addr));
        chk("resp_wr", W'(pmem_write), W'(e.wr));
        if (e.wr) chk("resp_wdata", pmem_wdata, e.wdata);
        else chk("resp_rdata", e.is_d ? d_pmem_rdata : i_pmem_rdata, pattern(e.addr));
      end
      if (d_pmem_resp) d_cnt++;
      if (i_pmem_resp) i_cnt++;
      since_resp = 0;
      if (!hold) begin
        if (d_pmem_resp) {d_pmem_read, d_pmem_write} = 0;
        if (i_pmem_resp) {i_pmem_read, i_pmem_write} = 0;
      end
    end
  endtask

  task automatic run(input int left);
    int n = 0;
    while (sb.size() > left && n < 300) begin
      tick();
      n++;
    end
    if (sb.size() > left) begin
      chk("timeout", W'(sb.size()), W'(left));
      sb.delete();
    end
  endtask

  task automatic push(input logic is_d, input logic wr, input logic [31:0] a, input logic [W-1:0] wd);
    txn_t e;
    e.is_d = is_d;
    e.wr = wr;
    e.addr = a;
    e.wdata = wd;
    sb.push_back(e);
  endtask

  task automatic set_vec(input int k, input logic ir, iw, dr, dw, input logic [31:0] ia, da,
                         input logic [W-1:0] iwd, dwd, input logic d_first, input int l);
    vecs[k].ir = ir; vecs[k].iw = iw; vecs[k].dr = dr; vecs[k].dw = dw;
    vecs[k].ia = ia; vecs[k].da = da; vecs[k].iwd = iwd; vecs[k].dwd = dwd;
    vecs[k].d_first = d_first; vecs[k].lat = l;
  endtask

  initial begin
    // last starts at I: conflicts go D,I in vectors 1/2, then I,D in 4 after a D-only grant
    set_vec(0, 1, 0, 0, 0, 32'h100, 32'h0,   '0, '0, 0, 5);
    set_vec(1, 1, 0, 0, 1, 32'h100, 32'h200, '0, {8{32'hB0B0_B0B0}}, 1, 4);
    set_vec(2, 0, 1, 1, 0, 32'h180, 32'h280, {8{32'h1234_5678}}, '0, 1, 2);
    set_vec(3, 0, 0, 1, 0, 32'h0,   32'h400, '0, '0, 1, 3);
    set_vec(4, 1, 0, 1, 0, 32'h500, 32'h600, '0, '0, 0, 1);
    set_vec(5, 0, 1, 0, 0, 32'h700, 32'h0,   {8{32'hCAFE_F00D}}, '0, 0, 6);

    repeat (2) @(negedge clk);
    chk("rst_read", W'(pmem_read), W'(0));
    chk("rst_write", W'(pmem_write), W'(0));
    chk("rst_addr", W'(pmem_address), W'(0));
    chk("rst_wdata", pmem_wdata, '0);
    chk("rst_resp", W'({i_pmem_resp, d_pmem_resp}), W'(0));
    chk("rst_rdata", i_pmem_rdata | d_pmem_rdata, '0);
    rst = 0;

    foreach (vecs[k]) begin
      vec_t v = vecs[k];
      tick();
      lat = v.lat;
      {i_pmem_read, i_pmem_write, i_pmem_address, i_pmem_wdata} = {v.ir, v.iw, v.ia, v.iwd};
      {d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata} = {v.dr, v.dw, v.da, v.dwd};
      if (v.d_first) begin
        if (v.dr | v.dw) push(1, v.dw, v.da, v.dwd);
        if (v.ir | v.iw) push(0, v.iw, v.ia, v.iwd);
      end else begin
        if (v.ir | v.iw) push(0, v.iw, v.ia, v.iwd);
        if (v.dr | v.dw) push(1, v.dw, v.da, v.dwd);
      end
      since_resp = 1;
      run(0);
    end

    // both requesters hold continuously: grants must alternate D,I,D,I,D,I
    tick();
    lat = 2;
    i_cnt = 0;
    d_cnt = 0;
    hold = 1;
    {i_pmem_read, i_pmem_address} = {1'b1, 32'h800};
    {d_pmem_read, d_pmem_address} = {1'b1, 32'h900};
    for (int j = 0; j < 3; j++) begin
      push(1, 0, 32'h900, '0);
      push(0, 0, 32'h800, '0);
    end
    since_resp = 1;
    run(0);
    hold = 0;
    {i_pmem_read, d_pmem_read} = 0;
    chk("alt_i_cnt", W'(i_cnt), W'(3));
    chk("alt_d_cnt", W'(d_cnt), W'(3));

    // stray resp in IDLE must not be forwarded
    tick();
    tick();
    force_resp = 1;
    #1;
    chk("idle_resp", W'({i_pmem_resp, d_pmem_resp}), W'(0));
    tick();
    force_resp = 0;
    chk("idle_stay", W'({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp}), W'(0));

    // reset two cycles into a D write, I request held through reset
    lat = 20;
    {d_pmem_write, d_pmem_address, d_pmem_wdata} = {1'b1, 32'hA00, {8{32'hDEAD_BEEF}}};
    push(1, 1, 32'hA00, {8{32'hDEAD_BEEF}});
    since_resp = 1;
    tick();
    tick();
    rst = 1;
    d_pmem_write = 0;
    {i_pmem_read, i_pmem_address} = {1'b1, 32'hB00};
    sb.delete();
    since_resp = 100;
    tick();
    chk("rst_mid_write", W'(pmem_write), W'(0));
    chk("rst_mid_read", W'(pmem_read), W'(0));
    chk("rst_mid_addr", W'(pmem_address), W'(0));
    rst = 0;
    lat = 3;
    push(0, 0, 32'hB00, '0);
    since_resp = 1;
    run(0);

    // D write-back then immediate D read: one IDLE bubble between them
    tick();
    {d_pmem_write, d_pmem_address, d_pmem_wdata} = {1'b1, 32'h300, {8{32'h0F0F_0F0F}}};
    push(1, 1, 32'h300, {8{32'h0F0F_0F0F}});
    push(1, 0, 32'h340, '0);
    since_resp = 1;
    run(1);
    {d_pmem_read, d_pmem_address} = {1'b1, 32'h340};
    run(0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
